// File: rtl/mmio_router_pkg.sv
`default_nettype none
// ============================================================================
// mmio_router_pkg : shared types and constants for the MMIO address router
// Rev 1.0
// ============================================================================
package mmio_router_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [31:0] ERR_RDATA         = 32'hDEADBEEF;
  localparam logic [19:0] DEFAULT_MMIO_PAGE = 20'haaaaa;

  typedef struct packed {
    logic [11:0] base;
    logic [11:0] size;
  } window_t;

  // Limit is computed on 13 bits so a window touching the page top cannot wrap.
  function automatic logic in_window(input logic [11:0] off, input window_t win);
    logic [12:0] lim;
    lim = {1'b0, win.base} + {1'b0, win.size};
    return ({1'b0, off} >= {1'b0, win.base}) && ({1'b0, off} < lim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_router_if.sv
`default_nettype none
// ============================================================================
// mmio_router_if : core request/response, memory and slave-side bus bundle
// Rev 1.0
// ============================================================================
interface mmio_router_if #(
  parameter int NUM_SLV = 4
);
  logic [31:0]           req_addr;
  logic                  req_rd;
  logic                  req_wr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_be;
  logic [31:0]           rdata;
  logic                  hold;
  logic                  err;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [31:0]           mem_rdata;
  logic [NUM_SLV-1:0]    sl_sel;
  logic                  sl_rd;
  logic                  sl_wr;
  logic [11:0]           sl_off;
  logic [31:0]           sl_wdata;
  logic [3:0]            sl_be;
  logic [NUM_SLV*32-1:0] sl_rdata;
  logic [NUM_SLV-1:0]    sl_ready;

  // Environment side: core, data memory and peripherals.
  modport master (
    output req_addr, req_rd, req_wr, req_wdata, req_be, mem_rdata, sl_rdata, sl_ready,
    input  rdata, hold, err, mem_rd, mem_wr, sl_sel, sl_rd, sl_wr, sl_off, sl_wdata, sl_be
  );

  // Router side.
  modport slave (
    input  req_addr, req_rd, req_wr, req_wdata, req_be, mem_rdata, sl_rdata, sl_ready,
    output rdata, hold, err, mem_rd, mem_wr, sl_sel, sl_rd, sl_wr, sl_off, sl_wdata, sl_be
  );
endinterface
`default_nettype wire

// File: rtl/mmio_window_decode.sv
`default_nettype none
// ============================================================================
// mmio_window_decode : combinational page/window decode with RO checking
// Rev 1.0
// ============================================================================
module mmio_window_decode
  import mmio_router_pkg::*;
#(
  parameter int                 NUM_SLV            = 4,
  parameter logic [19:0]        MMIO_PAGE          = DEFAULT_MMIO_PAGE,
  parameter logic [11:0]        SLV_BASE [NUM_SLV] = '{12'h400, 12'h500, 12'h600, 12'h700},
  parameter logic [11:0]        SLV_SIZE [NUM_SLV] = '{12'h008, 12'h002, 12'h020, 12'h008},
  parameter logic [NUM_SLV-1:0] SLV_RO             = '0
) (
  input  logic [31:0]        i_addr,
  input  logic               i_wr,
  output logic               o_page_hit,
  output logic [NUM_SLV-1:0] o_hit,
  output logic               o_unmapped,
  output logic               o_ro_viol
);

  logic [NUM_SLV-1:0] w_in_win;
  logic               w_found;

  assign o_page_hit = (i_addr[31:12] == MMIO_PAGE);

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_win
    window_t w_win;
    assign w_win       = '{base: SLV_BASE[g], size: SLV_SIZE[g]};
    assign w_in_win[g] = in_window(i_addr[11:0], w_win);
  end

  // Overlapping windows resolve to the lowest index.
  always_comb begin
    o_hit   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (o_page_hit && w_in_win[i] && !w_found) begin
        o_hit[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign o_unmapped = o_page_hit & ~(|o_hit);
  assign o_ro_viol  = i_wr & (|(o_hit & SLV_RO));

endmodule
`default_nettype wire

// File: rtl/mmio_router.sv
`default_nettype none
// ============================================================================
// mmio_router : data-side router to memory and NUM_SLV MMIO windows with
//               wait-states, core hold, timeout abort and error response
// Rev 1.0
// ============================================================================
module mmio_router
  import mmio_router_pkg::*;
#(
  parameter int                 NUM_SLV            = 4,
  parameter logic [19:0]        MMIO_PAGE          = DEFAULT_MMIO_PAGE,
  parameter logic [11:0]        SLV_BASE [NUM_SLV] = '{12'h400, 12'h500, 12'h600, 12'h700},
  parameter logic [11:0]        SLV_SIZE [NUM_SLV] = '{12'h008, 12'h002, 12'h020, 12'h008},
  parameter logic [NUM_SLV-1:0] SLV_RO             = '0,
  parameter int                 TIMEOUT            = 16
) (
  input  logic        clk,
  input  logic        rst,
  mmio_router_if.slave bus
);

  localparam int               c_idx_w    = $clog2(NUM_SLV + 1);
  localparam logic [c_idx_w-1:0] c_idx_none = c_idx_w'(NUM_SLV);
  localparam logic [7:0]       c_timeout  = 8'(TIMEOUT);

  logic                 w_page_hit, w_unmapped, w_ro_viol;
  logic [NUM_SLV-1:0]   w_hit;
  logic                 w_req, w_both, w_err_acc, w_mem_acc, w_slv_acc;
  logic [c_idx_w-1:0]   w_hit_idx;
  logic [NUM_SLV-1:0]   w_wait_sel;
  logic [31:0]          w_slv_rdata;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt;
  logic [c_idx_w-1:0]   r_idx, w_idx_nxt;
  logic [NUM_SLV-1:0]   w_sel;
  logic                 w_sl_rd, w_sl_wr, w_hold, w_mem_rd, w_mem_wr;
  logic                 w_cpl, w_tmo, w_err_cpl;

  logic [31:0]          r_rdata;
  logic                 r_err;
  logic                 r_mem_pend;

  mmio_window_decode #(
    .NUM_SLV   (NUM_SLV),
    .MMIO_PAGE (MMIO_PAGE),
    .SLV_BASE  (SLV_BASE),
    .SLV_SIZE  (SLV_SIZE),
    .SLV_RO    (SLV_RO)
  ) u_decode (
    .i_addr     (bus.req_addr),
    .i_wr       (bus.req_wr),
    .o_page_hit (w_page_hit),
    .o_hit      (w_hit),
    .o_unmapped (w_unmapped),
    .o_ro_viol  (w_ro_viol)
  );

  assign w_req     = bus.req_rd | bus.req_wr;
  assign w_both    = bus.req_rd & bus.req_wr;
  assign w_err_acc = w_req & (w_both | w_unmapped | w_ro_viol);
  assign w_mem_acc = w_req & ~w_both & ~w_page_hit;
  assign w_slv_acc = w_req & ~w_both & w_page_hit & ~w_unmapped & ~w_ro_viol;

  always_comb begin
    w_hit_idx  = c_idx_none;
    w_wait_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_hit[i])
        w_hit_idx = c_idx_w'(i);
      w_wait_sel[i] = (r_idx == c_idx_w'(i));
    end
  end

  always_comb begin
    w_slv_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_sel[i])
        w_slv_rdata = bus.sl_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= c_idx_none;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_sel       = '0;
    w_sl_rd     = 1'b0;
    w_sl_wr     = 1'b0;
    w_hold      = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_cpl       = 1'b0;
    w_tmo       = 1'b0;
    w_err_cpl   = 1'b0;
    case (r_state)
      IDLE: begin
        w_err_cpl = w_err_acc;
        if (w_mem_acc) begin
          w_mem_rd = bus.req_rd;
          w_mem_wr = bus.req_wr;
        end
        if (w_slv_acc) begin
          w_sel   = w_hit;
          w_sl_rd = bus.req_rd;
          w_sl_wr = bus.req_wr;
          if (|(w_hit & bus.sl_ready)) begin
            w_cpl = 1'b1;
          end else begin
            w_hold      = 1'b1;
            w_state_nxt = WAIT;
            w_cnt_nxt   = 8'd1;
            w_idx_nxt   = w_hit_idx;
          end
        end
      end
      WAIT: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = c_idx_none;
        // A dropped request simply falls back to IDLE without a response.
        if (w_req) begin
          if (r_cnt >= c_timeout) begin
            w_tmo = 1'b1;
          end else begin
            w_sel   = w_wait_sel;
            w_sl_rd = bus.req_rd;
            w_sl_wr = bus.req_wr;
            if (|(w_wait_sel & bus.sl_ready)) begin
              w_cpl = 1'b1;
            end else begin
              w_hold      = 1'b1;
              w_state_nxt = WAIT;
              w_cnt_nxt   = r_cnt + 8'd1;
              w_idx_nxt   = r_idx;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      w_sel     = '0;
      w_sl_rd   = 1'b0;
      w_sl_wr   = 1'b0;
      w_hold    = 1'b0;
      w_mem_rd  = 1'b0;
      w_mem_wr  = 1'b0;
      w_cpl     = 1'b0;
      w_tmo     = 1'b0;
      w_err_cpl = 1'b0;
    end
  end

  // Memory data arrives a cycle after the strobe and is passed straight through,
  // then latched so rdata keeps holding it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_mem_pend <= 1'b0;
    end else begin
      r_err      <= w_err_cpl | w_tmo;
      r_mem_pend <= w_mem_rd | w_mem_wr;
      if (w_cpl)
        r_rdata <= w_sl_rd ? w_slv_rdata : 32'h0;
      else if (w_err_cpl)
        r_rdata <= 32'h0;
      else if (w_tmo)
        r_rdata <= ERR_RDATA;
      else if (r_mem_pend)
        r_rdata <= bus.mem_rdata;
    end
  end

  assign bus.rdata    = r_mem_pend ? bus.mem_rdata : r_rdata;
  assign bus.err      = r_err;
  assign bus.hold     = w_hold;
  assign bus.mem_rd   = w_mem_rd;
  assign bus.mem_wr   = w_mem_wr;
  assign bus.sl_sel   = w_sel;
  assign bus.sl_rd    = w_sl_rd;
  assign bus.sl_wr    = w_sl_wr;
  assign bus.sl_off   = bus.req_addr[11:0];
  assign bus.sl_wdata = bus.req_wdata;
  assign bus.sl_be    = bus.req_be;

endmodule
`default_nettype wire

// File: doc/mmio_router.md
Name: mmio_router

Overview:
- Parametrised data-side address router between the core data bus and N memory-mapped peripherals plus the shared data memory.
- Decodes each access into one of NUM_SLV programmable windows inside the 4 KiB MMIO page, or into the memory path.
- Drives per-slave strobes and returns read data registered one cycle after completion.
- Adds what fixed decoding lacks: slave wait-states via a ready handshake, core stall (hold), timeout abort, read-only windows and an error response.

Parameters:
- NUM_SLV, 4, number of MMIO slave windows (1..8).
- MMIO_PAGE, 20'haaaaa, upper 20 address bits selecting the MMIO page.
- SLV_BASE, {12'h400,12'h500,12'h600,12'h700}, per-slave window base offset in the page (12 bits each).
- SLV_SIZE, {12'h008,12'h002,12'h020,12'h008}, per-slave window size in bytes; window is [BASE, BASE+SIZE).
- SLV_RO, 4'b0000, per-slave read-only mask; bit i set means writes to slave i are errors.
- TIMEOUT, 16, maximum wait cycles before abort (range 2..255).

Ports:
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- req_addr in 32: byte address.
- req_rd in 1: read request.
- req_wr in 1: write request.
- req_wdata in 32: write data.
- req_be in 4: byte enables.
- rdata out 32: read data to core.
- hold out 1: core stall; the core keeps the request stable while hold=1.
- err out 1: one-cycle error pulse, aligned with rdata.
- mem_rd out 1: memory read strobe.
- mem_wr out 1: memory write strobe.
- mem_rdata in 32: memory read data, valid one cycle after mem_rd.
- sl_sel out NUM_SLV: one-hot slave select.
- sl_rd out 1: slave read strobe.
- sl_wr out 1: slave write strobe.
- sl_off out 12: offset within the page (req_addr[11:0]).
- sl_wdata out 32: write data to slaves.
- sl_be out 4: byte enables to slaves.
- sl_rdata in NUM_SLV*32: slave read data, slave i at [32i+31:32i], valid while its sl_ready is high.
- sl_ready in NUM_SLV: slave accepts/completes in this cycle.

Behaviour:
- Decode (combinational):
  - page_hit = req_addr[31:12]==MMIO_PAGE.
  - Slave i hits when page_hit and SLV_BASE[i] <= off < SLV_BASE[i]+SLV_SIZE[i]. Sums are 13-bit, so no wrap.
  - Overlapping windows: the lowest index wins.
  - Not page_hit goes to the memory path.
  - page_hit with no window hit is unmapped.
- Memory path: mem_rd/mem_wr = req_rd/req_wr, never holds. On the next cycle rdata = mem_rdata and err = 0.
- Error accesses: unmapped, write to an SLV_RO slave, or req_rd & req_wr together. No strobes are driven; hold = 0; next cycle err = 1 and rdata = 32'h0.
- FSM states IDLE, WAIT.
  - IDLE with a valid slave access: sl_sel[i] = 1 and sl_rd/sl_wr follow the request.
    - If sl_ready[i] = 1: complete; hold = 0; stay in IDLE.
    - Otherwise: hold = 1 (combinational, same cycle); go to WAIT; wait counter = 1.
  - WAIT: strobes are re-driven from the held request and hold = 1 until sl_ready[i] = 1. That cycle completes, hold = 0, and the FSM returns to IDLE.
  - Each WAIT cycle without ready increments the counter. When the counter reaches TIMEOUT: strobes drop, hold = 0, go to IDLE; next cycle err = 1 and rdata = 32'hDEADBEEF.
  - If the request drops during WAIT (not expected), return to IDLE with no response.
- Response register, captured at completion and presented next cycle:
  - rdata = sl_rdata[i] for reads, 0 for writes.
  - err = 0.
  - rdata holds its value until the next completion; err is a one-cycle pulse.
- Throughput: back-to-back single-cycle slaves complete every cycle, one access per cycle.
- Reset: state IDLE, counter 0, rdata 0, err 0. hold, sl_sel and the strobes are 0 during reset.
  - Reset asserted mid-WAIT aborts with no response; hold = 0 in the cycle after reset deasserts unless a new wait begins.
- The slave index register is $clog2(NUM_SLV+1) bits wide; the extra code denotes memory/none.

Decomposition:
- Package mmio_router_pkg:
  - state enum {IDLE, WAIT}.
  - constants ERR_RDATA = 32'hDEADBEEF and default MMIO_PAGE.
  - window typedef (base, size 12-bit).
- One sub-module: mmio_window_decode. Purely combinational; produces the one-hot hit, unmapped flag and ro_violation flag from addr/wr. It is instantiated once and is unit-testable.

Test Plan:
- Memory path: read 0x00010040 with mem_rdata = 0x12345678 -> mem_rd = 1, hold = 0, next cycle rdata = 0x12345678, err = 0; no sl_sel.
- Zero-wait read: read 0xaaaaa404, slave 0 ready = 1, data 0xA5 -> sl_sel = 0001, sl_off = 0x404, next cycle rdata = 0xA5.
- Wait states: write 0xaaaaa600 with slave 2 ready low for 3 cycles -> hold = 1 for exactly 3 cycles, sl_wr held 4 cycles, then hold = 0 and err = 0.
- Timeout: read 0xaaaaa700 with slave 3 never ready, TIMEOUT = 16 -> hold high 16 cycles, then err pulse with rdata = 0xDEADBEEF.
- Error responses, all with no strobes and next-cycle err = 1, rdata = 0:
  - unmapped read at 0xaaaaa900;
  - write to slave 1 with SLV_RO = 4'b0010;
  - rd & wr asserted together.
- Reset mid-WAIT: assert rst at wait cycle 2 -> next cycle hold = 0, sl_sel = 0, err = 0; a following zero-wait access completes normally.
